float_point_adder_scheduler: RTL and testbench
==============================================

Name: float_point_adder_scheduler

Overview:
- Shares one float_point_adder instance between NUM_REQUESTERS clients.
- Uses round-robin arbitration and allows one operation in flight at a time.
- Latches the granted client's operands and drives them into the adder under the adder's issue handshake.
- Returns the adder result to the owning client only, tagged with that client's id.

Parameters:
- NUM_REQUESTERS, 4, number of client ports (2..16).
- REQUESTER_ID_WIDTH, 2, width of the client id; must equal ceil(log2(NUM_REQUESTERS)).
- OPERAND_EXPONENT_WIDTH_IN_BITS, 11, exponent field width (double precision).
- OPERAND_FRACTION_WIDTH_IN_BITS, 52, fraction field width (double precision).

Ports:
Client-side packed buses hold slice i at [i*W +: W]. E = exponent width, F = fraction width, N = NUM_REQUESTERS.
- clk_in  input  1  single clock; all logic on the rising edge.
- reset_in  input  1  synchronous, active-high reset.
- request_valid_in  input  N  client i has an operation pending.
- request_mode_in  input  N  per client: 0 = add, 1 = subtract.
- request_precision_in  input  N  per client precision select.
- request_sign_in  input  2N  per client {operand_1_sign, operand_0_sign}.
- request_exponent_in  input  2EN  per client {operand_1_exponent, operand_0_exponent}.
- request_fraction_in  input  2FN  per client {operand_1_fraction, operand_0_fraction}.
- request_ack_out  output  N  one-cycle grant pulse; the client must drop or replace its request next cycle.
- result_valid_out  output  N  result held for client i; one-hot or zero.
- result_sign_out  output  1  result sign.
- result_exponent_out  output  E  result exponent.
- result_fraction_out  output  F  result fraction.
- result_id_out  output  REQUESTER_ID_WIDTH  owner of the current result.
- result_ready_in  input  N  client i accepts its result.
- adder_operation_mode_out  output  1  to the adder; registered.
- adder_precision_out  output  1  to the adder; registered.
- adder_operand_valid_out  output  1  drives both adder operand valid inputs.
- adder_operand_0/1_sign/exponent/fraction_out  output  1/E/F  registered operand fields to the adder.
- adder_issue_ack_in  input  1  adder has captured the operands.
- adder_product_valid_in  input  1  adder result valid.
- adder_product_sign/exponent/fraction_in  input  1/E/F  adder result fields.
- adder_result_ack_out  output  1  releases the adder from its output state.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State = IDLE.
  - Round-robin pointer = 0.
  - Owner id = 0.
  - Reset asserted mid-operation abandons the in-flight operation; the adder is expected to be reset by the same reset_in.
- IDLE:
  - Grant the first asserted request_valid_in[k] scanning k = ptr, ptr+1, …, wrapping modulo N.
  - On grant in the same cycle:
    - pulse request_ack_out[k];
    - latch client k's mode, precision and operands into the adder registers;
    - set owner = k;
    - ptr <= (k+1) mod N;
    - go to ISSUE.
  - No request present: stay in IDLE; ptr unchanged.
- ISSUE:
  - adder_operand_valid_out = 1.
  - When adder_issue_ack_in = 1: clear adder_operand_valid_out next cycle and go to WAIT.
  - Operands stay stable until acknowledged.
- WAIT:
  - When adder_product_valid_in = 1: capture sign, exponent and fraction into the result registers.
  - Assert adder_result_ack_out for exactly that one cycle, then go to DELIVER.
- DELIVER:
  - result_valid_out = one-hot(owner); result_id_out = owner.
  - Result fields are held stable.
  - When result_ready_in[owner] = 1: clear result_valid_out next cycle and go to IDLE.
  - result_ready_in bits of non-owner clients are ignored.
- Latency:
  - Grant to adder operand valid: 1 cycle.
  - Result to the client: 1 cycle after adder_product_valid_in.
- Back-to-back operation: a new grant can occur in the cycle after DELIVER completes (IDLE cycle).
- Arbitration: there is no arbitration in non-IDLE states; requests arriving then wait with no loss.
- Fairness: a continuously requesting client is granted within N operations.
- At most one request_ack_out bit is high in any cycle.
- Illegal/unused state encodings return to IDLE.

Test Plan:
- Reset, then client 2 only: add 1.0 + 2.0 (exp 1023/1024).
  → request_ack_out = 4'b0100 once; adder sees operands one cycle later; result_valid_out = 4'b0100, result_id_out = 2; 3.0 is passed through.
- All four clients requesting continuously from reset.
  → grants in order 0, 1, 2, 3, 0; each result is tagged with the matching id.
- Adder withholds adder_issue_ack_in for 5 cycles.
  → adder_operand_valid_out and operands stay stable for 5 cycles; no new grant occurs.
- Owner holds result_ready_in low for 10 cycles while another client drives its ready bit high.
  → result stays held; state stays DELIVER; adder_result_ack_out pulsed only once.
- Pointer at 3, requests from clients 1 and 3.
  → client 3 granted first, then client 1 (wrap-around).
- reset_in asserted during WAIT.
  → next cycle all outputs are 0, state IDLE, ptr = 0; a subsequent request from client 0 is granted normally.

Source files
------------

// File: rtl/float_point_adder_scheduler.sv
// Round-robin scheduler that time-shares one floating-point adder between
// NUM_REQUESTERS clients, one operation in flight, results routed back by id.
module float_point_adder_scheduler #(
  parameter int NUM_REQUESTERS                 = 4,
  parameter int REQUESTER_ID_WIDTH             = 2,
  parameter int OPERAND_EXPONENT_WIDTH_IN_BITS = 11,
  parameter int OPERAND_FRACTION_WIDTH_IN_BITS = 52
) (
  input  logic                                                       clk_in,
  input  logic                                                       reset_in,
  input  logic [NUM_REQUESTERS-1:0]                                  request_valid_in,
  input  logic [NUM_REQUESTERS-1:0]                                  request_mode_in,
  input  logic [NUM_REQUESTERS-1:0]                                  request_precision_in,
  input  logic [2*NUM_REQUESTERS-1:0]                                request_sign_in,
  input  logic [2*OPERAND_EXPONENT_WIDTH_IN_BITS*NUM_REQUESTERS-1:0] request_exponent_in,
  input  logic [2*OPERAND_FRACTION_WIDTH_IN_BITS*NUM_REQUESTERS-1:0] request_fraction_in,
  output logic [NUM_REQUESTERS-1:0]                                  request_ack_out,
  output logic [NUM_REQUESTERS-1:0]                                  result_valid_out,
  output logic                                                       result_sign_out,
  output logic [OPERAND_EXPONENT_WIDTH_IN_BITS-1:0]                  result_exponent_out,
  output logic [OPERAND_FRACTION_WIDTH_IN_BITS-1:0]                  result_fraction_out,
  output logic [REQUESTER_ID_WIDTH-1:0]                              result_id_out,
  input  logic [NUM_REQUESTERS-1:0]                                  result_ready_in,
  output logic                                                       adder_operation_mode_out,
  output logic                                                       adder_precision_out,
  output logic                                                       adder_operand_valid_out,
  output logic                                                       adder_operand_0_sign_out,
  output logic [OPERAND_EXPONENT_WIDTH_IN_BITS-1:0]                  adder_operand_0_exponent_out,
  output logic [OPERAND_FRACTION_WIDTH_IN_BITS-1:0]                  adder_operand_0_fraction_out,
  output logic                                                       adder_operand_1_sign_out,
  output logic [OPERAND_EXPONENT_WIDTH_IN_BITS-1:0]                  adder_operand_1_exponent_out,
  output logic [OPERAND_FRACTION_WIDTH_IN_BITS-1:0]                  adder_operand_1_fraction_out,
  input  logic                                                       adder_issue_ack_in,
  input  logic                                                       adder_product_valid_in,
  input  logic                                                       adder_product_sign_in,
  input  logic [OPERAND_EXPONENT_WIDTH_IN_BITS-1:0]                  adder_product_exponent_in,
  input  logic [OPERAND_FRACTION_WIDTH_IN_BITS-1:0]                  adder_product_fraction_in,
  output logic                                                       adder_result_ack_out
);
  localparam int N   = NUM_REQUESTERS;
  localparam int IDW = REQUESTER_ID_WIDTH;
  localparam int E   = OPERAND_EXPONENT_WIDTH_IN_BITS;
  localparam int F   = OPERAND_FRACTION_WIDTH_IN_BITS;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic           mode_q, mode_d;
  logic           prec_q, prec_d;
  logic           opv_q, opv_d;
  logic           op0_s_q, op0_s_d, op1_s_q, op1_s_d;
  logic [E-1:0]   op0_e_q, op0_e_d, op1_e_q, op1_e_d;
  logic [F-1:0]   op0_f_q, op0_f_d, op1_f_q, op1_f_d;
  logic           res_s_q, res_s_d;
  logic [E-1:0]   res_e_q, res_e_d;
  logic [F-1:0]   res_f_q, res_f_d;
  logic [N-1:0]   res_vld_q, res_vld_d;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  // Rotating priority scan starting at the round-robin pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!grant_found && request_valid_in[(int'(ptr_q) + i) % N]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(ptr_q) + i) % N);
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    ptr_d                = ptr_q;
    owner_d              = owner_q;
    mode_d               = mode_q;
    prec_d               = prec_q;
    opv_d                = opv_q;
    op0_s_d              = op0_s_q;
    op0_e_d              = op0_e_q;
    op0_f_d              = op0_f_q;
    op1_s_d              = op1_s_q;
    op1_e_d              = op1_e_q;
    op1_f_d              = op1_f_q;
    res_s_d              = res_s_q;
    res_e_d              = res_e_q;
    res_f_d              = res_f_q;
    res_vld_d            = res_vld_q;
    request_ack_out      = '0;
    adder_result_ack_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          request_ack_out[grant_idx] = 1'b1;
          mode_d  = request_mode_in[grant_idx];
          prec_d  = request_precision_in[grant_idx];
          op0_s_d = request_sign_in[int'(grant_idx)*2];
          op1_s_d = request_sign_in[int'(grant_idx)*2 + 1];
          op0_e_d = request_exponent_in[int'(grant_idx)*2*E +: E];
          op1_e_d = request_exponent_in[int'(grant_idx)*2*E + E +: E];
          op0_f_d = request_fraction_in[int'(grant_idx)*2*F +: F];
          op1_f_d = request_fraction_in[int'(grant_idx)*2*F + F +: F];
          owner_d = grant_idx;
          ptr_d   = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
          opv_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (adder_issue_ack_in) begin
          opv_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (adder_product_valid_in) begin
          res_s_d              = adder_product_sign_in;
          res_e_d              = adder_product_exponent_in;
          res_f_d              = adder_product_fraction_in;
          res_vld_d            = '0;
          res_vld_d[owner_q]   = 1'b1;
          adder_result_ack_out = 1'b1;
          state_d              = S_DELIVER;
        end
      end
      S_DELIVER: begin
        // Only the owning client's ready bit can retire the result.
        if (result_ready_in[owner_q]) begin
          res_vld_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        opv_d     = 1'b0;
        res_vld_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      mode_q    <= 1'b0;
      prec_q    <= 1'b0;
      opv_q     <= 1'b0;
      op0_s_q   <= 1'b0;
      op0_e_q   <= '0;
      op0_f_q   <= '0;
      op1_s_q   <= 1'b0;
      op1_e_q   <= '0;
      op1_f_q   <= '0;
      res_s_q   <= 1'b0;
      res_e_q   <= '0;
      res_f_q   <= '0;
      res_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      mode_q    <= mode_d;
      prec_q    <= prec_d;
      opv_q     <= opv_d;
      op0_s_q   <= op0_s_d;
      op0_e_q   <= op0_e_d;
      op0_f_q   <= op0_f_d;
      op1_s_q   <= op1_s_d;
      op1_e_q   <= op1_e_d;
      op1_f_q   <= op1_f_d;
      res_s_q   <= res_s_d;
      res_e_q   <= res_e_d;
      res_f_q   <= res_f_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign adder_operation_mode_out     = mode_q;
  assign adder_precision_out          = prec_q;
  assign adder_operand_valid_out      = opv_q;
  assign adder_operand_0_sign_out     = op0_s_q;
  assign adder_operand_0_exponent_out = op0_e_q;
  assign adder_operand_0_fraction_out = op0_f_q;
  assign adder_operand_1_sign_out     = op1_s_q;
  assign adder_operand_1_exponent_out = op1_e_q;
  assign adder_operand_1_fraction_out = op1_f_q;
  assign result_valid_out             = res_vld_q;
  assign result_sign_out              = res_s_q;
  assign result_exponent_out          = res_e_q;
  assign result_fraction_out          = res_f_q;
  assign result_id_out                = (state_q == S_DELIVER) ? owner_q : '0;

endmodule

// File: tb/tb_float_point_adder_scheduler.sv
// Directed bench for float_point_adder_scheduler; the bench plays the adder.
module tb_float_point_adder_scheduler;
  logic         clk_in = 1'b0;
  logic         reset_in;
  logic [3:0]   request_valid_in, request_mode_in, request_precision_in;
  logic [7:0]   request_sign_in;
  logic [87:0]  request_exponent_in;
  logic [415:0] request_fraction_in;
  logic [3:0]   request_ack_out, result_valid_out, result_ready_in;
  logic         result_sign_out;
  logic [10:0]  result_exponent_out;
  logic [51:0]  result_fraction_out;
  logic [1:0]   result_id_out;
  logic         adder_operation_mode_out, adder_precision_out, adder_operand_valid_out;
  logic         adder_operand_0_sign_out, adder_operand_1_sign_out;
  logic [10:0]  adder_operand_0_exponent_out, adder_operand_1_exponent_out;
  logic [51:0]  adder_operand_0_fraction_out, adder_operand_1_fraction_out;
  logic         adder_issue_ack_in, adder_product_valid_in, adder_product_sign_in;
  logic [10:0]  adder_product_exponent_in;
  logic [51:0]  adder_product_fraction_in;
  logic         adder_result_ack_out;

  int tests = 0;
  int fails = 0;

  logic        cm[4], cp[4], s0[4], s1[4];
  logic [10:0] e0[4], e1[4];
  logic [51:0] f0[4], f1[4];

  float_point_adder_scheduler dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .request_valid_in(request_valid_in), .request_mode_in(request_mode_in),
    .request_precision_in(request_precision_in), .request_sign_in(request_sign_in),
    .request_exponent_in(request_exponent_in), .request_fraction_in(request_fraction_in),
    .request_ack_out(request_ack_out), .result_valid_out(result_valid_out),
    .result_sign_out(result_sign_out), .result_exponent_out(result_exponent_out),
    .result_fraction_out(result_fraction_out), .result_id_out(result_id_out),
    .result_ready_in(result_ready_in),
    .adder_operation_mode_out(adder_operation_mode_out),
    .adder_precision_out(adder_precision_out),
    .adder_operand_valid_out(adder_operand_valid_out),
    .adder_operand_0_sign_out(adder_operand_0_sign_out),
    .adder_operand_0_exponent_out(adder_operand_0_exponent_out),
    .adder_operand_0_fraction_out(adder_operand_0_fraction_out),
    .adder_operand_1_sign_out(adder_operand_1_sign_out),
    .adder_operand_1_exponent_out(adder_operand_1_exponent_out),
    .adder_operand_1_fraction_out(adder_operand_1_fraction_out),
    .adder_issue_ack_in(adder_issue_ack_in),
    .adder_product_valid_in(adder_product_valid_in),
    .adder_product_sign_in(adder_product_sign_in),
    .adder_product_exponent_in(adder_product_exponent_in),
    .adder_product_fraction_in(adder_product_fraction_in),
    .adder_result_ack_out(adder_result_ack_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_ops();
    for (int k = 0; k < 4; k++) begin
      request_mode_in[k]            = cm[k];
      request_precision_in[k]       = cp[k];
      request_sign_in[k*2 +: 2]     = {s1[k], s0[k]};
      request_exponent_in[k*22 +: 22] = {e1[k], e0[k]};
      request_fraction_in[k*104 +: 104] = {f1[k], f0[k]};
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " ack"},   64'(request_ack_out), 64'h0);
    chk({tag, " rvld"},  64'(result_valid_out), 64'h0);
    chk({tag, " rid"},   64'(result_id_out), 64'h0);
    chk({tag, " rexp"},  64'(result_exponent_out), 64'h0);
    chk({tag, " opv"},   64'(adder_operand_valid_out), 64'h0);
    chk({tag, " op0e"},  64'(adder_operand_0_exponent_out), 64'h0);
    chk({tag, " op1f"},  64'(adder_operand_1_fraction_out), 64'h0);
    chk({tag, " rack"},  64'(adder_result_ack_out), 64'h0);
    chk({tag, " state"}, 64'(dut.state_q), 64'h0);
    chk({tag, " ptr"},   64'(dut.ptr_q), 64'h0);
  endtask

  // One full operation for client k; called at a negedge with requests already driven.
  task automatic do_op(input int k, input bit drop, input int idly, input int rdly,
                       input logic [10:0] pe, input logic [51:0] pf);
    logic [3:0] oh;
    oh = 4'(1 << k);
    #1 chk($sformatf("grant%0d", k), 64'(request_ack_out), 64'(oh));
    @(negedge clk_in);
    if (drop) request_valid_in[k] = 1'b0;
    chk("ack_pulse", 64'(request_ack_out), 64'h0);
    chk("opv", 64'(adder_operand_valid_out), 64'h1);
    chk("mode", 64'(adder_operation_mode_out), 64'(cm[k]));
    chk("prec", 64'(adder_precision_out), 64'(cp[k]));
    chk("op0e", 64'(adder_operand_0_exponent_out), 64'(e0[k]));
    chk("op1e", 64'(adder_operand_1_exponent_out), 64'(e1[k]));
    chk("op0f", 64'(adder_operand_0_fraction_out), 64'(f0[k]));
    chk("op1f", 64'(adder_operand_1_fraction_out), 64'(f1[k]));
    chk("op1s", 64'(adder_operand_1_sign_out), 64'(s1[k]));
    for (int i = 0; i < idly; i++) begin
      @(negedge clk_in);
      chk("opv_hold", 64'(adder_operand_valid_out), 64'h1);
      chk("op0e_hold", 64'(adder_operand_0_exponent_out), 64'(e0[k]));
      chk("no_grant_issue", 64'(request_ack_out), 64'h0);
    end
    adder_issue_ack_in = 1'b1;
    @(negedge clk_in);
    adder_issue_ack_in = 1'b0;
    chk("opv_clr", 64'(adder_operand_valid_out), 64'h0);
    chk("no_grant_wait", 64'(request_ack_out), 64'h0);
    adder_product_valid_in    = 1'b1;
    adder_product_sign_in     = k[0];
    adder_product_exponent_in = pe;
    adder_product_fraction_in = pf;
    #1 chk("rack_on", 64'(adder_result_ack_out), 64'h1);
    @(negedge clk_in);
    adder_product_valid_in = 1'b0;
    chk("rack_off", 64'(adder_result_ack_out), 64'h0);
    chk("rvld", 64'(result_valid_out), 64'(oh));
    chk("rid", 64'(result_id_out), 64'(k));
    chk("rsign", 64'(result_sign_out), 64'(k[0]));
    chk("rexp", 64'(result_exponent_out), 64'(pe));
    chk("rfrac", 64'(result_fraction_out), 64'(pf));
    for (int i = 0; i < rdly; i++) begin
      result_ready_in = ~oh;
      @(negedge clk_in);
      chk("rvld_hold", 64'(result_valid_out), 64'(oh));
      chk("rexp_hold", 64'(result_exponent_out), 64'(pe));
      chk("state_deliver", 64'(dut.state_q), 64'h3);
      chk("rack_once", 64'(adder_result_ack_out), 64'h0);
    end
    result_ready_in = oh;
    @(negedge clk_in);
    result_ready_in = '0;
    chk("rvld_clr", 64'(result_valid_out), 64'h0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      cm[k] = k[0]; cp[k] = k[1]; s0[k] = k[1]; s1[k] = ~k[0];
      e0[k] = 11'(100 + k); e1[k] = 11'(200 + k);
      f0[k] = 52'(k + 5);   f1[k] = 52'(k + 9);
    end
    reset_in = 1'b1;
    request_valid_in = '0; request_mode_in = '0; request_precision_in = '0;
    request_sign_in = '0; request_exponent_in = '0; request_fraction_in = '0;
    result_ready_in = '0; adder_issue_ack_in = 1'b0; adder_product_valid_in = 1'b0;
    adder_product_sign_in = 1'b0; adder_product_exponent_in = '0; adder_product_fraction_in = '0;
    @(negedge clk_in);
    @(negedge clk_in);
    chk_zero_outputs("reset");
    reset_in = 1'b0;

    // 1.0 + 2.0 = 3.0 from client 2
    cm[2] = 1'b0; s0[2] = 1'b0; s1[2] = 1'b0;
    e0[2] = 11'd1023; e1[2] = 11'd1024; f0[2] = '0; f1[2] = '0;
    pack_ops();
    request_valid_in = 4'b0100;
    do_op(2, 1'b1, 0, 0, 11'd1024, 52'h8000000000000);
    chk("ptr_after_c2", 64'(dut.ptr_q), 64'h3);
    e0[2] = 11'd102; e1[2] = 11'd202; f0[2] = 52'd7; f1[2] = 52'd11; s0[2] = 1'b1; s1[2] = 1'b1;
    pack_ops();

    // Continuous requests from reset: 0,1,2,3,0
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    chk("ptr_reset2", 64'(dut.ptr_q), 64'h0);
    request_valid_in = 4'b1111;
    do_op(0, 1'b0, 0, 0, 11'd300, 52'd1);
    do_op(1, 1'b0, 0, 0, 11'd301, 52'd8);
    do_op(2, 1'b0, 0, 0, 11'd302, 52'd15);
    do_op(3, 1'b0, 0, 0, 11'd303, 52'd22);
    do_op(0, 1'b0, 0, 0, 11'd304, 52'd29);
    request_valid_in = '0;
    chk("ptr_after_rr", 64'(dut.ptr_q), 64'h1);

    // Issue stall 5 cycles and owner withholding ready 10 cycles, client 3 waiting
    request_valid_in = 4'b1010;
    do_op(1, 1'b1, 5, 10, 11'd500, 52'hABCDE);
    do_op(3, 1'b1, 0, 0, 11'd501, 52'h12345);
    chk("ptr_after_stall", 64'(dut.ptr_q), 64'h0);

    // Wrap-around: move pointer to 3, then clients 1 and 3 request
    request_valid_in = 4'b0100;
    do_op(2, 1'b1, 0, 0, 11'd600, 52'd6);
    chk("ptr_at3", 64'(dut.ptr_q), 64'h3);
    request_valid_in = 4'b1010;
    do_op(3, 1'b1, 0, 0, 11'd601, 52'd7);
    do_op(1, 1'b1, 0, 0, 11'd602, 52'd8);

    // Reset while waiting on the adder result
    request_valid_in = 4'b0001;
    #1 chk("grant0_pre_reset", 64'(request_ack_out), 64'h1);
    @(negedge clk_in);
    request_valid_in = '0;
    adder_issue_ack_in = 1'b1;
    @(negedge clk_in);
    adder_issue_ack_in = 1'b0;
    chk("state_wait", 64'(dut.state_q), 64'h2);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    chk_zero_outputs("mid_reset");
    request_valid_in = 4'b0001;
    do_op(0, 1'b1, 0, 0, 11'd700, 52'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
